// File: rtl/bs_param.sv
// bs_param: binary-search engine over a private sorted lookup memory.
// Memory depth is 2**ADDR_W words of DATA_W bits, loaded through a write
// port while the engine is not busy. Reads are synchronous (1-cycle), so
// every probe is a READ/CMP state pair.
// Optional macro LOWEST_MATCH_EN: keep searching after a hit so that Loc
// ends up at the lowest index holding the key (default: stop on first hit).
module bs_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] A,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              Busy,
    output logic              Done,
    output logic              Found,
    output logic [ADDR_W-1:0] Loc
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] RIGHT_INIT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] key;
    logic [ADDR_W:0]   left, right, mid;
    logic [ADDR_W+1:0] sum;
    logic              found_q;
    logic [ADDR_W-1:0] loc_q;
    logic              accept, eq, lt, at_left, at_right;

    // Pointers are ADDR_W+1 bits; the sum gets one more bit so the midpoint never wraps.
    assign sum      = {1'b0, left} + {1'b0, right};
    assign mid      = sum[ADDR_W+1:1];
    assign accept   = (state == S_IDLE) && Start;
    assign eq       = (key == rd_data);
    assign lt       = (key < rd_data);
    assign at_left  = (mid == left);
    assign at_right = (mid == right);

    // State register; reset aborts any search in flight.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (Start) state_nxt = S_READ;
            S_READ: state_nxt = S_CMP;
            S_CMP: begin
                if (eq) begin
`ifdef LOWEST_MATCH_EN
                    state_nxt = at_left ? S_DONE : S_READ;
`else
                    state_nxt = S_DONE;
`endif
                end else if (lt) begin
                    state_nxt = at_left ? S_DONE : S_READ;
                end else begin
                    state_nxt = at_right ? S_DONE : S_READ;
                end
            end
            S_DONE: if (!Start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        Busy = (state == S_READ) || (state == S_CMP);
        Done = (state == S_DONE);
    end

    assign Found = found_q;
    assign Loc   = loc_q;

    // Search datapath: key capture, window narrowing and result recording.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            key     <= '0;
            left    <= '0;
            right   <= '0;
            found_q <= 1'b0;
            loc_q   <= '0;
        end else if (accept) begin
            key     <= A;
            left    <= '0;
            right   <= RIGHT_INIT;
            found_q <= 1'b0;
            loc_q   <= '0;
        end else if (state == S_CMP) begin
            if (eq) begin
                found_q <= 1'b1;
                loc_q   <= mid[ADDR_W-1:0];
`ifdef LOWEST_MATCH_EN
                // Keep looking left of the hit for a lower duplicate.
                if (!at_left) right <= mid - ONE;
`endif
            end else if (lt) begin
                if (!at_left) right <= mid - ONE;
            end else begin
                if (!at_right) left <= mid + ONE;
            end
        end
    end

    // Lookup memory: loads only while idle/done, registered read of mid in S_READ.
    always_ff @(posedge clk) begin
        if (wr_en && !Busy) mem[wr_addr] <= wr_data;
        if (state == S_READ) rd_data <= mem[mid[ADDR_W-1:0]];
    end

endmodule

// File: tb/tb_bs_param.sv
// Directed bench for bs_param: loads mem[i]=2*i, runs searches, and checks
// results against a scoreboard queue filled when each search is launched.
module tb_bs_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int MAXLAT = 2 * (ADDR_W + 1);

    typedef struct {
        logic [DATA_W-1:0] key;
        logic              found;
        logic [ADDR_W-1:0] loc;
        int                exact_lat;   // 0 = only bound by MAXLAT
    } exp_t;

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic [DATA_W-1:0] A = '0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              Busy, Done, Found;
    logic [ADDR_W-1:0] Loc;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bs_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .Reset(Reset), .Start(Start), .A(A),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .Busy(Busy), .Done(Done), .Found(Found), .Loc(Loc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 2 ** ADDR_W; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(2 * i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic load_const(input logic [DATA_W-1:0] v);
        for (int i = 0; i < 2 ** ADDR_W; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = v;
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // Launch a search from S_IDLE (called at a negedge), follow it to Done
    // and compare against the scoreboard entry. With hold=1 Start is raised
    // again at Done so the engine parks in S_DONE; otherwise it returns to idle.
    task automatic search(input logic [DATA_W-1:0] key, input logic ef,
                          input logic [ADDR_W-1:0] el, input int lat,
                          input bit poke, input bit hold);
        exp_t e;
        int   n = 0;
        bit   busy_ok = 1'b1;
        bit   timed_out = 1'b0;
        e.key = key; e.found = ef; e.loc = el; e.exact_lat = lat;
        sb.push_back(e);
        A = key; Start = 1'b1;
        @(posedge clk);                   // accepting edge
        @(negedge clk);
        Start = 1'b0; A = ~key;           // A only matters on the accepting edge
        check("clear_on_accept", {Found, 27'(Loc)}, 32'd0);
        if (poke) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(10); wr_data = '0;
        end
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            wr_en = 1'b0;
            if (Done) break;
            if (Busy !== 1'b1) busy_ok = 1'b0;
            if (n > MAXLAT + 2) begin timed_out = 1'b1; break; end
        end
        e = sb.pop_front();
        check("no_timeout", 32'(timed_out), 32'd0);
        check("busy_during_search", 32'(busy_ok), 32'd1);
        if (e.exact_lat != 0) check("latency_exact", n, e.exact_lat);
        else                  check("latency_bound", 32'(n <= MAXLAT), 32'd1);
        check("found", 32'(Found), 32'(e.found));
        if (e.found) check("loc", 32'(Loc), 32'(e.loc));
        if (hold) begin
            Start = 1'b1;
        end else begin
            @(negedge clk);
            check("back_idle_done", 32'(Done), 32'd0);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_found", 32'(Found), 32'd0);
        check("rst_loc", 32'(Loc), 32'd0);
        Reset = 1'b0;
        @(negedge clk);

        load_ramp();

        // Hits at the top, bottom and first probe.
        search(8'd62, 1'b1, 5'd31, 0, 1'b0, 1'b0);
        search(8'd0,  1'b1, 5'd0,  0, 1'b0, 1'b0);
        search(8'd30, 1'b1, 5'd15, 2, 1'b0, 1'b0);

        // Misses; the write attempted during the second one must be dropped.
        search(8'd7,   1'b0, 5'd0, 0, 1'b0, 1'b0);
        search(8'd255, 1'b0, 5'd0, 0, 1'b1, 1'b1);

        // Parked in S_DONE with Start held: no new search.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_done", 32'(Done), 32'd1);
            check("hold_busy", 32'(Busy), 32'd0);
        end
        Start = 1'b0;
        @(negedge clk);
        check("idle_after_drop", 32'(Done), 32'd0);
        check("idle_not_busy", 32'(Busy), 32'd0);

        search(8'd40, 1'b1, 5'd20, 0, 1'b0, 1'b0);
        check("found_held_idle", 32'(Found), 32'd1);
        check("loc_held_idle", 32'(Loc), 32'd20);
        search(8'd20, 1'b1, 5'd10, 0, 1'b0, 1'b0);

        // Reset while the engine is in S_CMP.
        A = 8'd62; Start = 1'b1;
        @(posedge clk);                   // accept -> S_READ
        @(negedge clk);
        Start = 1'b0;
        @(posedge clk);                   // -> S_CMP
        @(negedge clk);
        check("in_cmp_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_found", 32'(Found), 32'd0);
        check("midrst_loc", 32'(Loc), 32'd0);
        Reset = 1'b0;
        @(negedge clk);
        search(8'd4, 1'b1, 5'd2, 0, 1'b0, 1'b0);

        // All-duplicate memory.
        load_const(8'd5);
`ifdef LOWEST_MATCH_EN
        search(8'd5, 1'b1, 5'd0, 0, 1'b0, 1'b0);
`else
        search(8'd5, 1'b1, 5'd15, 2, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
